// File: rtl/mips_bonus_core.sv
// rtl/mips_bonus_core.sv - single-cycle 32-bit MIPS-subset core
// with on-chip instruction, register and data memories.

module mips_pc (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] next_pc,
   output logic [31:0] pc
);
   logic [31:0] PCreg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) PCreg <= 32'd0;
      else        PCreg <= next_pc;
   end

   assign pc = PCreg;
endmodule

module mips_imem #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   input  logic [AW-1:0] addr,
   output logic [31:0]   instr
);
   logic [31:0] IMEM [0:DEPTH-1];

   // Normally filled by preload; the load port is kept so the array has an owner.
   always_ff @(posedge clk) begin
      if (load_en) IMEM[load_addr] <= load_data;
   end

   assign instr = IMEM[addr];
endmodule

module mips_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data,
   input  logic        we,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data
);
   logic [31:0] RMEM [0:31];

   // Contents survive reset; rst_n only blocks a write at the edge.
   always_ff @(posedge clk) begin
      if (rst_n && we && (wr_addr != 5'd0)) RMEM[wr_addr] <= wr_data;
   end

   assign rs_data = (rs_addr == 5'd0) ? 32'd0 : RMEM[rs_addr];
   assign rt_data = (rt_addr == 5'd0) ? 32'd0 : RMEM[rt_addr];
endmodule

module mips_dmem #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] DMEM [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (rst_n && we) DMEM[addr] <= wdata;
   end

   assign rdata = DMEM[addr];
endmodule

module mips_bonus_core #(
   parameter int IMEM_DEPTH = 256,
   parameter int DMEM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] result
);
   // Depths are powers of two, so slicing the word index gives the modulo wrap.
   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);

   logic [31:0] pc, next_pc, pc_plus4, instr;
   logic [31:0] rs_val, rt_val, mem_rdata;
   logic [31:0] sext, zext, alu, wr_data;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt, wr_addr;
   logic [15:0] imm;
   logic        reg_we, mem_we;

   mips_pc PC (
      .clk     (clk),
      .rst_n   (rst_n),
      .next_pc (next_pc),
      .pc      (pc)
   );

   mips_imem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) IM (
      .clk       (clk),
      .load_en   (1'b0),
      .load_addr ({IAW{1'b0}}),
      .load_data (32'd0),
      .addr      (pc[IAW+1:2]),
      .instr     (instr)
   );

   mips_regfile REG (
      .clk     (clk),
      .rst_n   (rst_n),
      .rs_addr (rs),
      .rt_addr (rt),
      .rs_data (rs_val),
      .rt_data (rt_val),
      .we      (reg_we),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   mips_dmem #(.DEPTH(DMEM_DEPTH), .AW(DAW)) DATAMEM (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (alu[DAW+1:2]),
      .we    (mem_we),
      .wdata (rt_val),
      .rdata (mem_rdata)
   );

   assign opcode   = instr[31:26];
   assign rs       = instr[25:21];
   assign rt       = instr[20:16];
   assign rd       = instr[15:11];
   assign shamt    = instr[10:6];
   assign funct    = instr[5:0];
   assign imm      = instr[15:0];
   assign sext     = {{16{imm[15]}}, imm};
   assign zext     = {16'd0, imm};
   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      alu     = 32'd0;
      reg_we  = 1'b0;
      wr_addr = rt;
      wr_data = 32'd0;
      mem_we  = 1'b0;
      next_pc = pc_plus4;
      case (opcode)
         6'h00: begin
            wr_addr = rd;
            reg_we  = 1'b1;
            case (funct)
               6'h20, 6'h21: alu = rs_val + rt_val;
               6'h22, 6'h23: alu = rs_val - rt_val;
               6'h24:        alu = rs_val & rt_val;
               6'h25:        alu = rs_val | rt_val;
               6'h26:        alu = rs_val ^ rt_val;
               6'h27:        alu = ~(rs_val | rt_val);
               6'h2A:        alu = {31'd0, $signed(rs_val) < $signed(rt_val)};
               6'h2B:        alu = {31'd0, rs_val < rt_val};
               6'h00:        alu = rt_val << shamt;
               6'h02:        alu = rt_val >> shamt;
               6'h03:        alu = $signed(rt_val) >>> shamt;
               6'h08: begin
                  alu     = rs_val;
                  reg_we  = 1'b0;
                  next_pc = rs_val;
               end
               default:      reg_we = 1'b0;
            endcase
            wr_data = alu;
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            case (opcode)
               6'h08, 6'h09: alu = rs_val + sext;
               6'h0A:        alu = {31'd0, $signed(rs_val) < $signed(sext)};
               6'h0B:        alu = {31'd0, rs_val < sext};
               6'h0C:        alu = rs_val & zext;
               6'h0D:        alu = rs_val | zext;
               6'h0E:        alu = rs_val ^ zext;
               default:      alu = {imm, 16'd0};
            endcase
            reg_we  = 1'b1;
            wr_data = alu;
         end
         6'h23: begin
            alu     = rs_val + sext;
            reg_we  = 1'b1;
            wr_data = mem_rdata;
         end
         6'h2B: begin
            alu    = rs_val + sext;
            mem_we = 1'b1;
         end
         6'h04, 6'h05: begin
            alu = rs_val - rt_val;
            if ((rs_val == rt_val) == (opcode == 6'h04))
               next_pc = pc_plus4 + {sext[29:0], 2'b00};
         end
         6'h02, 6'h03: begin
            alu     = pc_plus4;
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            // jal links through $31; j leaves the register file alone.
            reg_we  = (opcode == 6'h03);
            wr_addr = 5'd31;
            wr_data = pc_plus4;
         end
         default: ;
      endcase
   end

   assign result = rst_n ? alu : 32'd0;
endmodule

// File: tb/tb_mips_bonus_core.sv
// tb/tb_mips_bonus_core.sv - directed and randomized program checks of mips_bonus_core
// against an instruction-level reference model.

module tb_mips_bonus_core;
   logic        clk;
   logic        rst_n;
   logic [31:0] result;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_reg  [0:31];
   logic [31:0] m_dmem [0:255];
   logic [31:0] m_imem [0:255];
   logic [31:0] m_pc;

   logic [31:0] m_res, m_npc, m_wd, m_md;
   logic [4:0]  m_wa;
   logic [7:0]  m_ma;
   logic        m_rwe, m_mwe, m_res_known;

   mips_bonus_core #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .result (result)
   );

   initial clk = 1'b0;
   always #25 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] s,
                                         input logic [4:0] t, input logic [4:0] d,
                                         input logic [4:0] sh);
      return {6'h00, s, t, d, sh, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] im);
      return {op, s, t, im};
   endfunction

   task automatic set_reg(input int i, input logic [31:0] v);
      m_reg[i] = (i == 0) ? 32'd0 : v;
      dut.REG.RMEM[i] = m_reg[i];
   endtask

   task automatic set_dmem(input int i, input logic [31:0] v);
      m_dmem[i] = v;
      dut.DATAMEM.DMEM[i] = v;
   endtask

   task automatic set_imem(input int i, input logic [31:0] v);
      m_imem[i] = v;
      dut.IM.IMEM[i] = v;
   endtask

   // Architectural effect of the instruction at m_pc, not yet committed.
   task automatic model_eval();
      logic [31:0] ins, a, b, se, ze, p4, addr;
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd, sh;
      logic        alu_wr;
      ins = m_imem[m_pc[9:2]];
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
      rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
      a  = m_reg[rs];  b  = m_reg[rt];
      se = {{16{ins[15]}}, ins[15:0]};
      ze = {16'd0, ins[15:0]};
      p4 = m_pc + 4;
      addr = a + se;
      m_res = 0; m_npc = p4; m_rwe = 0; m_wa = rt; m_wd = 0;
      m_mwe = 0; m_ma = addr[9:2]; m_md = b; m_res_known = 1;
      alu_wr = 0;
      if (op == 6'h00) begin
         m_wa = rd;
         alu_wr = 1;
         case (fn)
            6'h20, 6'h21: m_res = a + b;
            6'h22, 6'h23: m_res = a - b;
            6'h24: m_res = a & b;
            6'h25: m_res = a | b;
            6'h26: m_res = a ^ b;
            6'h27: m_res = ~(a | b);
            6'h2A: m_res = ($signed(a) < $signed(b)) ? 1 : 0;
            6'h2B: m_res = (a < b) ? 1 : 0;
            6'h00: m_res = b << sh;
            6'h02: m_res = b >> sh;
            6'h03: m_res = $signed(b) >>> sh;
            6'h08: begin m_npc = a; alu_wr = 0; m_res_known = 0; end
            default: alu_wr = 0;
         endcase
      end else begin
         case (op)
            6'h08, 6'h09: begin m_res = a + se; alu_wr = 1; end
            6'h0A: begin m_res = ($signed(a) < $signed(se)) ? 1 : 0; alu_wr = 1; end
            6'h0B: begin m_res = (a < se) ? 1 : 0; alu_wr = 1; end
            6'h0C: begin m_res = a & ze; alu_wr = 1; end
            6'h0D: begin m_res = a | ze; alu_wr = 1; end
            6'h0E: begin m_res = a ^ ze; alu_wr = 1; end
            6'h0F: begin m_res = ze << 16; alu_wr = 1; end
            6'h23: begin m_res = addr; m_rwe = 1; m_wd = m_dmem[addr[9:2]]; end
            6'h2B: begin m_res = addr; m_mwe = 1; end
            6'h04: begin m_res = a - b; if (a == b) m_npc = p4 + se * 4; end
            6'h05: begin m_res = a - b; if (a != b) m_npc = p4 + se * 4; end
            6'h02, 6'h03: begin
               m_res = p4;
               m_npc = {p4[31:28], ins[25:0], 2'b00};
               if (op == 6'h03) begin m_rwe = 1; m_wa = 31; m_wd = p4; end
            end
            default: ;
         endcase
      end
      if (alu_wr) begin m_rwe = 1; m_wd = m_res; end
   endtask

   task automatic model_commit();
      if (m_rwe && m_wa != 0) m_reg[m_wa] = m_wd;
      if (m_mwe) m_dmem[m_ma] = m_md;
      m_pc = m_npc;
   endtask

   // Entered and left on a falling edge.
   task automatic step();
      model_eval();
      #1;
      if (m_res_known) check("result", result, m_res);
      @(posedge clk);
      if (rst_n) model_commit();
      @(negedge clk);
      check("pc", dut.PC.PCreg, m_pc);
   endtask

   task automatic begin_prog();
      rst_n = 1'b0;
      @(negedge clk);
      m_pc = 0;
      for (int i = 0; i < 256; i++) begin
         set_imem(i, 32'd0);
         set_dmem(i, 32'd0);
      end
      for (int i = 0; i < 32; i++) set_reg(i, 32'd0);
   endtask

   task automatic release_reset();
      #1;
      check("reset_pc", dut.PC.PCreg, 32'd0);
      check("reset_result", result, 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic mid_reset();
      rst_n = 1'b0;
      #1;
      check("midrst_pc", dut.PC.PCreg, 32'd0);
      check("midrst_result", result, 32'd0);
      m_pc = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic compare_state(input string tag);
      for (int i = 0; i < 32; i++) check({tag, "_rmem"}, dut.REG.RMEM[i], m_reg[i]);
      for (int i = 0; i < 256; i++) check({tag, "_dmem"}, dut.DATAMEM.DMEM[i], m_dmem[i]);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] fns [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                               6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
      logic [5:0] iops [8] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
      logic [4:0]  s, t, d, sh;
      logic [15:0] im, off;
      s  = 5'($urandom_range(0, 7));
      t  = 5'($urandom_range(0, 7));
      d  = 5'($urandom_range(0, 7));
      sh = 5'($urandom);
      im = 16'($urandom);
      off = 16'($urandom_range(0, 6)) - 16'd3;
      case ($urandom_range(0, 13))
         0, 1, 2, 3: return enc_r(fns[$urandom_range(0, 12)], s, t, d, sh);
         4, 5, 6:    return enc_i(iops[$urandom_range(0, 7)], s, t, im);
         7:          return enc_i(6'h23, s, t, im);
         8:          return enc_i(6'h2B, s, t, im);
         9:          return enc_i(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, s, t, off);
         10:         return {($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03,
                             26'($urandom_range(0, 40))};
         11:         return enc_r(6'h08, s, 5'd0, 5'd0, 5'd0);
         12:         return enc_r(6'h01, s, t, d, sh);
         default:    return {6'h3F, 26'($urandom)};
      endcase
   endfunction

   task automatic run_random(input string tag, input bit do_reset);
      int steps;
      begin_prog();
      for (int i = 1; i < 32; i++) set_reg(i, $urandom);
      for (int i = 0; i < 256; i++) set_dmem(i, $urandom);
      for (int i = 0; i < 26; i++) set_imem(i, rand_instr());
      release_reset();
      steps = 0;
      while (m_pc <= 104 && steps < 300) begin
         if (do_reset && steps == 8) mid_reset();
         step();
         steps++;
      end
      compare_state(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      begin_prog();
      set_reg(1, 32'd5);
      set_reg(2, 32'd7);
      set_reg(9, 32'd20);
      set_dmem(1, 32'hDEADBEEF);
      set_imem(0,  enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0));
      set_imem(1,  enc_r(6'h22, 5'd1, 5'd2, 5'd4, 5'd0));
      set_imem(2,  enc_r(6'h2A, 5'd4, 5'd1, 5'd5, 5'd0));
      set_imem(3,  enc_r(6'h2B, 5'd4, 5'd1, 5'd5, 5'd0));
      set_imem(4,  enc_i(6'h23, 5'd0, 5'd6, 16'd4));
      set_imem(5,  enc_i(6'h2B, 5'd0, 5'd6, 16'd8));
      set_imem(6,  enc_i(6'h08, 5'd0, 5'd0, 16'd9));
      set_imem(7,  enc_i(6'h0F, 5'd0, 5'd7, 16'h1234));
      set_imem(8,  enc_i(6'h0D, 5'd7, 5'd7, 16'h5678));
      set_imem(9,  enc_i(6'h23, 5'd9, 5'd9, 16'hFFF0));
      set_imem(10, enc_i(6'h05, 5'd1, 5'd1, 16'd5));
      set_imem(11, {6'h03, 26'h10});
      set_imem(16, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF));
      release_reset();

      step();
      check("add_rmem3", dut.REG.RMEM[3], 32'h0000000C);
      check("add_pc", dut.PC.PCreg, 32'd4);
      step();
      check("sub_rmem4", dut.REG.RMEM[4], 32'hFFFFFFFE);
      step();
      check("slt_rmem5", dut.REG.RMEM[5], 32'd1);
      step();
      check("sltu_rmem5", dut.REG.RMEM[5], 32'd0);
      step();
      check("lw_rmem6", dut.REG.RMEM[6], 32'hDEADBEEF);
      step();
      check("sw_dmem2", dut.DATAMEM.DMEM[2], 32'hDEADBEEF);
      step();
      check("addi_r0", dut.REG.RMEM[0], 32'd0);
      step();
      step();
      check("lui_ori_rmem7", dut.REG.RMEM[7], 32'h12345678);
      step();
      check("lw_self_rmem9", dut.REG.RMEM[9], 32'hDEADBEEF);
      step();
      check("bne_pc", dut.PC.PCreg, 32'd44);
      step();
      check("jal_pc", dut.PC.PCreg, 32'h40);
      check("jal_rmem31", dut.REG.RMEM[31], 32'd48);
      step();
      step();
      check("beq_loop_pc", dut.PC.PCreg, 32'h40);
      compare_state("directed");

      run_random("rand0", 1'b0);
      run_random("rand1", 1'b1);
      run_random("rand2", 1'b0);
      run_random("rand3", 1'b1);
      run_random("rand4", 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
